// File: rtl/updown_bcd_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_bcd_counter_if
// Purpose  : Bundle of pulse inputs and BCD/status outputs between the
//            push-button pulse stage and the up/down BCD counter.
// Revision : 1.0 - initial release
// ============================================================================
interface updown_bcd_counter_if;
  logic       en;
  logic       in_up_pulse;
  logic       in_down_pulse;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       at_max;
  logic       at_min;
  logic       wrap_pulse;

  // Pulse source side: drives requests, observes the count
  modport master (
    output en, in_up_pulse, in_down_pulse,
    input  bcd1, bcd0, at_max, at_min, wrap_pulse
  );

  // Counter side: consumes requests, produces the count
  modport slave (
    input  en, in_up_pulse, in_down_pulse,
    output bcd1, bcd0, at_max, at_min, wrap_pulse
  );
endinterface
`default_nettype wire

// File: rtl/updown_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_bcd_counter
// Purpose  : Two-digit BCD up/down counter driven by single-cycle pulses,
//            with wrap-around or saturating limits and a wrap indication.
// Revision : 1.0 - initial release
// ============================================================================
module updown_bcd_counter #(
  parameter int MAX_VAL = 99,   // upper limit in decimal, 1..99
  parameter bit WRAP    = 1'b1  // 1 = wrap at the limits, 0 = saturate
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  updown_bcd_counter_if.slave bus
);

  // Limit split into digits once so all compares stay per digit
  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       at_max_q;
  logic       at_min_q;
  logic       wrap_q;

  logic       do_inc;
  logic       do_dec;
  logic       cur_max;
  logic       cur_min;
  logic [3:0] next_tens;
  logic [3:0] next_ones;
  logic       next_wrap;

  // Decode the request and compute the next digit pair
  always_comb begin
    do_inc    = bus.en & bus.in_up_pulse & ~bus.in_down_pulse;
    do_dec    = bus.en & bus.in_down_pulse & ~bus.in_up_pulse;
    cur_max   = (tens == MAX_TENS) && (ones == MAX_ONES);
    cur_min   = (tens == 4'd0) && (ones == 4'd0);
    next_tens = tens;
    next_ones = ones;
    next_wrap = 1'b0;

    if (do_inc) begin
      if (cur_max) begin
        // At the limit: either roll to 00 or stay put
        if (WRAP) begin
          next_tens = 4'd0;
          next_ones = 4'd0;
          next_wrap = 1'b1;
        end
      end else if (ones == 4'd9) begin
        next_ones = 4'd0;
        next_tens = tens + 4'd1;
      end else begin
        next_ones = ones + 4'd1;
      end
    end else if (do_dec) begin
      if (cur_min) begin
        // At zero: either roll to the limit or stay put
        if (WRAP) begin
          next_tens = MAX_TENS;
          next_ones = MAX_ONES;
          next_wrap = 1'b1;
        end
      end else if (ones == 4'd0) begin
        next_ones = 4'd9;
        next_tens = tens - 4'd1;
      end else begin
        next_ones = ones - 4'd1;
      end
    end
  end

  // Register the value; flags come from the next value so they track the digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens     <= 4'd0;
      ones     <= 4'd0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      tens     <= next_tens;
      ones     <= next_ones;
      at_max_q <= (next_tens == MAX_TENS) && (next_ones == MAX_ONES);
      at_min_q <= (next_tens == 4'd0) && (next_ones == 4'd0);
      wrap_q   <= next_wrap;
    end
  end

  assign bus.bcd1       = tens;
  assign bus.bcd0       = ones;
  assign bus.at_max     = at_max_q;
  assign bus.at_min     = at_min_q;
  assign bus.wrap_pulse = wrap_q;

endmodule
`default_nettype wire
